uart_rx_frame_check: RTL and testbench

Parametrised frame-level checker for the UART receiver. It consumes sampled bits from the RX sampler and assembles the data word LSB-first. It checks the parity bit in one of four parity modes and checks one or two stop bits. It reports per-frame parity and stop (framing) errors and keeps saturating error counters for status registers.

---
 rtl/uart_rx_frame_check_if.sv | 35 +++
 rtl/uart_rx_frame_check.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_check_if.sv
// Bundle between the RX bit sampler and the frame checker.
// Carries per-frame config, the bit stream and the frame results.
interface uart_rx_frame_check_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              cfg_par_en;
    logic [1:0]        cfg_par_mode;
    logic              cfg_stop2;
    logic              frame_start;
    logic              bit_valid;
    logic              sampled_bit;
    logic              clr_cnt;
    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;
    logic              busy;
    logic [CNT_W-1:0]  par_err_cnt;
    logic [CNT_W-1:0]  stp_err_cnt;

    modport master (
        output cfg_par_en, cfg_par_mode, cfg_stop2,
        output frame_start, bit_valid, sampled_bit, clr_cnt,
        input  p_data, data_valid, par_err, stp_err, busy,
        input  par_err_cnt, stp_err_cnt
    );

    modport slave (
        input  cfg_par_en, cfg_par_mode, cfg_stop2,
        input  frame_start, bit_valid, sampled_bit, clr_cnt,
        output p_data, data_valid, par_err, stp_err, busy,
        output par_err_cnt, stp_err_cnt
    );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: LSB-first data assembly, parity and stop
// checking, and saturating error counters.
module uart_rx_frame_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic                clk,
    input logic                rst,
    uart_rx_frame_check_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              pe_q, pe_d;
    logic [1:0]        pm_q, pm_d;
    logic              s2_q, s2_d;
    logic              sc_q, sc_d;
    logic              perr_q, perr_d;
    logic              serr_q, serr_d;
    logic [DATA_W-1:0] pdat_q, pdat_d;
    logic              dv_q, dv_d;
    logic              pe_o_q, pe_o_d;
    logic              se_o_q, se_o_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic              exp_par;
    logic              done;
    logic              sb;

    assign sb = bus.sampled_bit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sh_q    <= '0;
            pe_q    <= 1'b0;
            pm_q    <= 2'b00;
            s2_q    <= 1'b0;
            sc_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            pdat_q  <= '0;
            dv_q    <= 1'b0;
            pe_o_q  <= 1'b0;
            se_o_q  <= 1'b0;
            pcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sh_q    <= sh_d;
            pe_q    <= pe_d;
            pm_q    <= pm_d;
            s2_q    <= s2_d;
            sc_q    <= sc_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            pdat_q  <= pdat_d;
            dv_q    <= dv_d;
            pe_o_q  <= pe_o_d;
            se_o_q  <= se_o_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        sh_d    = sh_q;
        pe_d    = pe_q;
        pm_d    = pm_q;
        s2_d    = s2_q;
        sc_d    = sc_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        pdat_d  = pdat_q;
        dv_d    = 1'b0;
        pe_o_d  = 1'b0;
        se_o_d  = 1'b0;
        done    = 1'b0;

        unique case (pm_q)
            2'b00:   exp_par = par_q;
            2'b01:   exp_par = ~par_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase

        // frame_start aborts any frame in flight and swallows a same-cycle bit
        if (bus.frame_start) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            sh_d    = '0;
            pe_d    = bus.cfg_par_en;
            pm_d    = bus.cfg_par_mode;
            s2_d    = bus.cfg_stop2;
            sc_d    = 1'b0;
            perr_d  = 1'b0;
            serr_d  = 1'b0;
        end else if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: ;
                DATA: begin
                    // shift in at the MSB so the first bit lands at bit 0
                    sh_d  = {sb, sh_q[DATA_W-1:1]};
                    par_d = par_q ^ sb;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1))
                        state_d = pe_q ? PARITY : STOP;
                end
                PARITY: begin
                    perr_d  = (sb != exp_par);
                    state_d = STOP;
                end
                STOP: begin
                    if (!sb) serr_d = 1'b1;
                    if (s2_q && !sc_q) begin
                        sc_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            dv_d   = 1'b1;
            pdat_d = sh_q;
            pe_o_d = perr_q;
            se_o_d = serr_q | ~sb;
        end

        pcnt_d = pcnt_q;
        if (bus.clr_cnt)
            pcnt_d = '0;
        else if (done && pe_o_d && pcnt_q != '1)
            pcnt_d = pcnt_q + CNT_W'(1);

        scnt_d = scnt_q;
        if (bus.clr_cnt)
            scnt_d = '0;
        else if (done && se_o_d && scnt_q != '1)
            scnt_d = scnt_q + CNT_W'(1);
    end

    assign bus.p_data      = pdat_q;
    assign bus.data_valid  = dv_q;
    assign bus.par_err     = pe_o_q;
    assign bus.stp_err     = se_o_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.par_err_cnt = pcnt_q;
    assign bus.stp_err_cnt = scnt_q;
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: an 8-bit/8-bit-counter and a
// 5-bit/2-bit-counter instance checked against a frame-level model.
module tb_uart_rx_frame_check;
    logic clk;
    logic rst;

    logic       fs [2];
    logic       bv [2];
    logic       sb [2];
    logic       pe [2];
    logic [1:0] pm [2];
    logic       s2 [2];
    logic       clr [2];

    logic [1:0] o_dv, o_pe, o_se, o_busy;
    logic [7:0] o_pd [2];
    logic [7:0] o_pc [2];
    logic [7:0] o_sc [2];

    int checks = 0;
    int errors = 0;
    int mp [2];
    int ms [2];
    int last_pd [2];
    int cmax [2];
    int dw [2];

    uart_rx_frame_check_if #(.DATA_W(8), .CNT_W(8)) if8 ();
    uart_rx_frame_check_if #(.DATA_W(5), .CNT_W(2)) if5 ();

    uart_rx_frame_check #(.DATA_W(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .bus(if8.slave)
    );
    uart_rx_frame_check #(.DATA_W(5), .CNT_W(2)) u5 (
        .clk(clk), .rst(rst), .bus(if5.slave)
    );

    assign if8.cfg_par_en   = pe[0];
    assign if8.cfg_par_mode = pm[0];
    assign if8.cfg_stop2    = s2[0];
    assign if8.frame_start  = fs[0];
    assign if8.bit_valid    = bv[0];
    assign if8.sampled_bit  = sb[0];
    assign if8.clr_cnt      = clr[0];
    assign if5.cfg_par_en   = pe[1];
    assign if5.cfg_par_mode = pm[1];
    assign if5.cfg_stop2    = s2[1];
    assign if5.frame_start  = fs[1];
    assign if5.bit_valid    = bv[1];
    assign if5.sampled_bit  = sb[1];
    assign if5.clr_cnt      = clr[1];

    assign o_dv   = {if5.data_valid, if8.data_valid};
    assign o_pe   = {if5.par_err, if8.par_err};
    assign o_se   = {if5.stp_err, if8.stp_err};
    assign o_busy = {if5.busy, if8.busy};
    assign o_pd[0] = if8.p_data;
    assign o_pd[1] = {3'b000, if5.p_data};
    assign o_pc[0] = if8.par_err_cnt;
    assign o_pc[1] = {6'b0, if5.par_err_cnt};
    assign o_sc[0] = if8.stp_err_cnt;
    assign o_sc[1] = {6'b0, if5.stp_err_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(int i, string t, bit dv, int pd, bit perr, bit serr);
        check($sformatf("%s[%0d].data_valid", t, i), int'(o_dv[i]), int'(dv));
        check($sformatf("%s[%0d].p_data", t, i), int'(o_pd[i]), pd);
        check($sformatf("%s[%0d].par_err", t, i), int'(o_pe[i]), int'(perr));
        check($sformatf("%s[%0d].stp_err", t, i), int'(o_se[i]), int'(serr));
        check($sformatf("%s[%0d].par_cnt", t, i), int'(o_pc[i]), mp[i]);
        check($sformatf("%s[%0d].stp_cnt", t, i), int'(o_sc[i]), ms[i]);
        check($sformatf("%s[%0d].busy", t, i), int'(o_busy[i]), 0);
    endtask

    task automatic put(int i, bit b);
        bv[i] = 1'b1;
        sb[i] = b;
        @(negedge clk);
        bv[i] = 1'b0;
        sb[i] = 1'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic bit want_par(int d, logic [1:0] m);
        bit ones;
        ones = bit'($countones(d) & 1);
        case (m)
            2'b00:   return ones;
            2'b01:   return ~ones;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic send(int i, int din, bit pen, logic [1:0] pmode, bit st2,
                        bit pbit, bit s_a, bit s_b, bit clr_end, int abort_at);
        int  d;
        bit  perr;
        bit  serr;
        d = din & ((1 << dw[i]) - 1);
        pe[i] = pen;
        pm[i] = pmode;
        s2[i] = st2;
        fs[i] = 1'b1;
        bv[i] = 1'($urandom);
        sb[i] = 1'($urandom);
        @(negedge clk);
        fs[i] = 1'b0;
        bv[i] = 1'b0;
        pe[i] = 1'($urandom);
        pm[i] = 2'($urandom);
        s2[i] = 1'($urandom);
        check($sformatf("start[%0d].busy", i), int'(o_busy[i]), 1);
        for (int k = 0; k < dw[i]; k++) begin
            if (k == abort_at) return;
            gap();
            put(i, bit'((d >> k) & 1));
            check($sformatf("mid[%0d].data_valid", i), int'(o_dv[i]), 0);
        end
        if (pen) begin
            gap();
            put(i, pbit);
        end
        if (st2) begin
            gap();
            put(i, s_a);
            check($sformatf("stop1[%0d].data_valid", i), int'(o_dv[i]), 0);
        end
        gap();
        clr[i] = clr_end;
        put(i, st2 ? s_b : s_a);
        clr[i] = 1'b0;
        perr = pen && (pbit != want_par(d, pmode));
        serr = !s_a || (st2 && !s_b);
        if (clr_end) begin
            mp[i] = 0;
            ms[i] = 0;
        end else begin
            if (perr && mp[i] < cmax[i]) mp[i]++;
            if (serr && ms[i] < cmax[i]) ms[i]++;
        end
        last_pd[i] = d;
        check_out(i, "done", 1'b1, d, perr, serr);
        @(negedge clk);
        check_out(i, "after", 1'b0, d, 1'b0, 1'b0);
    endtask

    initial begin
        cmax[0] = 255;
        cmax[1] = 3;
        dw[0]   = 8;
        dw[1]   = 5;
        for (int i = 0; i < 2; i++) begin
            fs[i] = 0; bv[i] = 0; sb[i] = 0; pe[i] = 0;
            pm[i] = 0; s2[i] = 0; clr[i] = 0;
            mp[i] = 0; ms[i] = 0; last_pd[i] = 0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_out(0, "reset", 1'b0, 0, 1'b0, 1'b0);
        check_out(1, "reset", 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // directed frames on the 8-bit instance
        send(0, 'hA5, 1, 2'b00, 0, 0, 1, 1, 0, -1);
        send(0, 'hA5, 1, 2'b00, 0, 1, 1, 1, 0, -1);
        send(0, 'hA5, 1, 2'b01, 0, 1, 1, 1, 0, -1);
        send(0, 'h00, 1, 2'b10, 0, 0, 1, 1, 0, -1);
        send(0, 'h00, 1, 2'b11, 0, 0, 1, 1, 0, -1);
        send(0, 'h3C, 0, 2'b00, 0, 0, 1, 1, 0, -1);
        send(0, 'h5A, 0, 2'b01, 1, 0, 1, 0, 0, -1);

        // idle bit strobes must be ignored
        put(0, 1'b1);
        check("idle.data_valid", int'(o_dv[0]), 0);
        check("idle.busy", int'(o_busy[0]), 0);

        // reset during data bits drops the frame
        send(0, 'hFF, 1, 2'b00, 0, 0, 1, 1, 0, 3);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mp[i] = 0; ms[i] = 0; last_pd[i] = 0;
        end
        check_out(0, "midrst", 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // saturation on the 2-bit counters, then clear on the sixth error
        for (int n = 0; n < 5; n++)
            send(1, 'h05, 1, 2'b00, 0, 1, 1, 1, 0, -1);
        send(1, 'h05, 1, 2'b00, 0, 1, 1, 1, 1, -1);

        // abort and restart on the 5-bit instance
        send(1, 'h13, 1, 2'b00, 0, 1, 1, 1, 0, -1);
        send(1, 'h1F, 1, 2'b00, 0, 0, 0, 0, 0, 3);
        send(1, 'h0A, 1, 2'b01, 1, 1, 1, 1, 0, -1);

        // randomized frames on both instances
        for (int n = 0; n < 80; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                put(i, 1'($urandom));
                check($sformatf("noise[%0d].data_valid", i), int'(o_dv[i]), 0);
            end
            send(i, int'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, dw[i] - 1)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
